// File: rtl/uart_tx_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Holds the FSM state enum, byte width and the tx_busy wait limit.
package uart_tx_arb_pkg;

    localparam int BYTE_W        = 8;
    localparam int WAIT_BUSY_MAX = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_WAIT_BUSY,
        ST_WAIT_DONE
    } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester byte streams plus the transmitter send_en/tx_busy handshake.
// slave: arbiter side; master: requesters and transmitter side.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    import uart_tx_arb_pkg::*;

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*BYTE_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      send_en;
    logic [BYTE_W-1:0]         send_data;
    logic                      tx_busy;

    modport slave (
        input  req_valid, req_data, req_last, tx_busy,
        output req_ready, send_en, send_data
    );

    modport master (
        output req_valid, req_data, req_last, tx_busy,
        input  req_ready, send_en, send_data
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin search starting at ptr+1 (mod NUM_REQ).
// In: req_valid, ptr. Out: winner index, any (some request present).
module uart_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IDW-1:0]     ptr,
    output logic [IDW-1:0]     winner,
    output logic               any
);

    logic [IDW-1:0] idx;

    always_comb begin
        winner = '0;
        any    = 1'b0;
        idx    = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = IDW'((int'(ptr) + i) % NUM_REQ);
            if (!any && req_valid[idx]) begin
                any    = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter sharing one UART transmitter among NUM_REQ
// requesters. Ports: clk, rst (sync, active-high), tx_if (slave modport:
// req_valid/req_data/req_last/req_ready, send_en/send_data/tx_busy),
// grant_active, grant_id, timeout_pulse.
// Optional packet idle timeout: define UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter
    import uart_tx_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 50_000
) (
    input  logic                       clk,
    input  logic                       rst,
    uart_tx_arbiter_if.slave           tx_if,
    output logic                       grant_active,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       timeout_pulse
);

    localparam int IDW  = $clog2(NUM_REQ);
    localparam int WB_W = $clog2(WAIT_BUSY_MAX);

    arb_state_t        state;
    arb_state_t        state_n;
    logic [IDW-1:0]    ptr;
    logic [IDW-1:0]    pick_id;
    logic              pick_any;
    logic              last_r;
    logic              cur_valid;
    logic              tmo_hit;
    logic [WB_W-1:0]   wb_cnt;
    logic [BYTE_W-1:0] bytes [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
        assign bytes[g] = tx_if.req_data[g*BYTE_W +: BYTE_W];
    end

    assign cur_valid = tx_if.req_valid[grant_id];

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req_valid (tx_if.req_valid),
        .ptr       (ptr),
        .winner    (pick_id),
        .any       (pick_any)
    );

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC);

    logic [TMO_W-1:0] tmo_cnt;

    // Counts consecutive starved LOAD cycles of the current grantee.
    assign tmo_hit = (state == ST_LOAD) && !cur_valid &&
                     (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt       <= '0;
            timeout_pulse <= 1'b0;
        end else begin
            timeout_pulse <= tmo_hit;
            if ((state == ST_LOAD) && !cur_valid && !tmo_hit)
                tmo_cnt <= tmo_cnt + 1'b1;
            else
                tmo_cnt <= '0;
        end
    end
`else
    logic unused_tmo;

    assign unused_tmo    = ^TIMEOUT_CYC;
    assign tmo_hit       = 1'b0;
    assign timeout_pulse = 1'b0;
`endif

    always_comb begin
        state_n = state;
        unique case (state)
            ST_IDLE:
                if (!tx_if.tx_busy && pick_any)
                    state_n = ST_LOAD;
            ST_LOAD:
                if (tmo_hit)
                    state_n = ST_IDLE;
                else if (cur_valid)
                    state_n = ST_SEND;
            ST_SEND:
                state_n = ST_WAIT_BUSY;
            ST_WAIT_BUSY:
                // A transmitter that never raises busy must not hang us.
                if (tx_if.tx_busy || (wb_cnt == WB_W'(WAIT_BUSY_MAX - 1)))
                    state_n = ST_WAIT_DONE;
            ST_WAIT_DONE:
                if (!tx_if.tx_busy)
                    state_n = last_r ? ST_IDLE : ST_LOAD;
            default:
                state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            ptr             <= IDW'(NUM_REQ - 1);
            grant_id        <= '0;
            tx_if.send_data <= '0;
            last_r          <= 1'b0;
            wb_cnt          <= '0;
        end else begin
            state <= state_n;
            if ((state == ST_IDLE) && (state_n == ST_LOAD))
                grant_id <= pick_id;
            if ((state == ST_LOAD) && (state_n == ST_SEND)) begin
                tx_if.send_data <= bytes[grant_id];
                last_r          <= tx_if.req_last[grant_id];
            end
            wb_cnt <= (state == ST_WAIT_BUSY) ? wb_cnt + 1'b1 : '0;
            if (((state == ST_WAIT_DONE) && (state_n == ST_IDLE)) || tmo_hit)
                ptr <= grant_id;
        end
    end

    assign grant_active  = (state != ST_IDLE);
    assign tx_if.send_en = (state == ST_SEND);

    always_comb begin
        tx_if.req_ready = '0;
        if (state == ST_LOAD)
            tx_if.req_ready[grant_id] = 1'b1;
    end

endmodule
